// File: rtl/wdt.sv
// rtl/wdt.sv - Watchdog timer slave: key-protected kick, interrupt on first miss, reset request on second.
module wdt #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] KICK_KEY  = 32'h5A5A_A5A5,
    parameter int unsigned       RST_PULSE = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ready_o,
    output logic              int_o,
    output logic              rst_req_o
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2,
        S_RESET   = 2'd3
    } state_e;

    localparam int unsigned       RCW       = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [RCW-1:0]    RCNT_INIT = RCW'(RST_PULSE - 1);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

    state_e            state_q;
    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        status_q;
    logic [2:0]        status_d;
    logic [RCW-1:0]    rcnt_q;
    logic              ready_q;
    logic              rst_req_q;

    logic [2:0]        sel;
    logic              accept;
    logic              wr;
    logic              rd;
    logic              wr_ctrl;
    logic              wr_load;
    logic              wr_kick;
    logic              wr_status;
    logic              en_clear;
    logic              kick_ok;
    logic              kick_bad;
    logic              last;
    logic              to_set;
    logic              rstd_set;
    logic              to_clr;
    logic [DATA_W-1:0] rdata;
    logic              unused_addr;

    assign sel         = addr_i[4:2];
    assign unused_addr = ^{addr_i[ADDR_W-1:5], addr_i[1:0]};

    // A request is taken only while ready is low, so a request held through
    // the completion cycle is never sampled twice.
    assign accept    = req_i & ~ready_q;
    assign wr        = accept & we_i;
    assign rd        = accept & ~we_i;
    assign wr_ctrl   = wr && (sel == 3'd0) && !ctrl_q[3];
    assign wr_load   = wr && (sel == 3'd1) && !ctrl_q[3];
    assign wr_kick   = wr && (sel == 3'd3);
    assign wr_status = wr && (sel == 3'd4);
    assign en_clear  = wr_ctrl && !data_i[0];
    assign kick_ok   = wr_kick && (data_i == KICK_KEY);
    assign kick_bad  = wr_kick && (data_i != KICK_KEY);
    assign last      = (count_q <= ONE);

    // A valid kick on the terminal edge suppresses the timeout event.
    assign to_set   = !en_clear && !kick_ok && last && (state_q == S_COUNT);
    assign rstd_set = !en_clear && !kick_ok && last && (state_q == S_EXPIRED) && ctrl_q[2];
    assign to_clr   = !en_clear && (state_q == S_RESET) && (rcnt_q == '0);

    always_comb begin
        status_d = status_q;
        if (wr_status) status_d = status_q & ~data_i[2:0];
        if (to_clr)    status_d[0] = 1'b0;
        if (to_set)    status_d[0] = 1'b1;
        if (kick_bad)  status_d[1] = 1'b1;
        if (rstd_set)  status_d[2] = 1'b1;
    end

    always_comb begin
        rdata = '0;
        case (sel)
            3'd0:    rdata[3:0] = ctrl_q;
            3'd1:    rdata      = load_q;
            3'd2:    rdata      = count_q;
            3'd4:    rdata[2:0] = status_q;
            default: rdata      = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            load_q    <= '1;
            count_q   <= '1;
            status_q  <= '0;
            rcnt_q    <= '0;
            ready_q   <= 1'b0;
            data_q    <= '0;
            rst_req_q <= 1'b0;
        end else begin
            ready_q  <= accept;
            data_q   <= rd ? rdata : '0;
            status_q <= status_d;
            if (wr_ctrl) ctrl_q <= data_i[3:0];
            if (wr_load) load_q <= (data_i == '0) ? ONE : data_i;

            if (en_clear) begin
                state_q   <= S_IDLE;
                rst_req_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        count_q <= load_q;
                        if (ctrl_q[0]) state_q <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (kick_ok || last) count_q <= load_q;
                        else                 count_q <= count_q - ONE;
                        if (to_set) state_q <= S_EXPIRED;
                    end
                    S_EXPIRED: begin
                        if (kick_ok) begin
                            count_q <= load_q;
                            state_q <= S_COUNT;
                        end else if (last) begin
                            if (ctrl_q[2]) begin
                                state_q   <= S_RESET;
                                rst_req_q <= 1'b1;
                                rcnt_q    <= RCNT_INIT;
                            end else begin
                                count_q <= load_q;
                            end
                        end else begin
                            count_q <= count_q - ONE;
                        end
                    end
                    S_RESET: begin
                        if (rcnt_q == '0) begin
                            rst_req_q <= 1'b0;
                            count_q   <= load_q;
                            state_q   <= S_COUNT;
                        end else begin
                            rcnt_q <= rcnt_q - 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_o    = data_q;
    assign ready_o   = ready_q;
    assign rst_req_o = rst_req_q;
    assign int_o     = status_q[0] & ctrl_q[1];

endmodule

// File: tb/tb_wdt.sv
// tb/tb_wdt.sv - Directed/randomized bench for wdt with an arithmetic timing model.
module tb_wdt;
    localparam logic [31:0] KEY = 32'h5A5A_A5A5;
    localparam int R_CTRL = 0, R_LOAD = 1, R_COUNT = 2, R_KICK = 3, R_STATUS = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        int_o;
    logic        rst_req_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] rd;
    int ce, e0, lval, d, rise, lim, width, x, lk;

    wdt dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .ready_o  (ready_o),
        .int_o    (int_o),
        .rst_req_o(rst_req_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Called #1 after an edge; req is held through the completion cycle on purpose.
    task automatic bus(input bit w, input int r, input logic [31:0] wd,
                       output logic [31:0] rdat, output int commit);
        req_i  = 1'b1;
        we_i   = w;
        addr_i = ($urandom() & 32'hFFFF_FFE3) | (32'(r) << 2);
        data_i = wd;
        @(posedge clk_i);
        #1;
        commit = cyc;
        check("ready_pulse", ready_o, 1);
        rdat = data_o;
        @(posedge clk_i);
        #1;
        check("ready_single", ready_o, 0);
        check("data_idle", data_o, 0);
        req_i  = 1'b0;
        we_i   = 1'b0;
        data_i = '0;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        idle(2);
        check("rst_ready", ready_o, 0);
        check("rst_data", data_o, 0);
        check("rst_int", int_o, 0);
        check("rst_rstreq", rst_req_o, 0);
        rst_i = 1'b0;
        bus(0, R_LOAD, 0, rd, ce);   check("rst_load", rd, 32'hFFFF_FFFF);
        bus(0, R_COUNT, 0, rd, ce);  check("rst_count", rd, 32'hFFFF_FFFF);
        bus(0, R_STATUS, 0, rd, ce); check("rst_status", rd, 0);
        bus(0, R_CTRL, 0, rd, ce);   check("rst_ctrl", rd, 0);
        bus(0, R_KICK, 0, rd, ce);   check("kick_reads0", rd, 0);

        // Timeout: count = L one edge after enable, TO L edges later.
        lval = $urandom_range(6, 20);
        d    = $urandom_range(0, lval - 4);
        bus(1, R_LOAD, lval, rd, ce);
        bus(1, R_CTRL, 32'h3, rd, e0);
        idle(d);
        bus(0, R_COUNT, 0, rd, ce);
        check("to_count", rd, 32'(lval - (ce - 2 - e0)));
        lim = cyc + 200;
        while (!int_o && cyc < lim) idle(1);
        check("to_int_rise", cyc, e0 + lval + 1);
        bus(0, R_STATUS, 0, rd, ce); check("to_status", rd, 1);
        bus(1, R_STATUS, 1, rd, ce); check("to_w1c_int", int_o, 0);
        bus(1, R_CTRL, 0, rd, ce);
        bus(1, R_STATUS, 7, rd, ce);

        // Second miss: reset pulse, then back to counting.
        lval = $urandom_range(3, 8);
        bus(1, R_LOAD, lval, rd, ce);
        bus(1, R_CTRL, 32'h7, rd, e0);
        lim = cyc + 300;
        while (!rst_req_o && cyc < lim) idle(1);
        check("rr_rise", cyc, e0 + 2 * lval + 1);
        width = 0;
        while (rst_req_o && width < 100) begin
            idle(1);
            width++;
        end
        check("rr_width", width, 16);
        x = cyc;
        bus(0, R_STATUS, 0, rd, ce); check("rr_status", rd, 32'h4);
        lim = cyc + 200;
        while (!int_o && cyc < lim) idle(1);
        check("rr_recount_to", cyc, x + lval);
        bus(1, R_CTRL, 0, rd, ce);
        bus(1, R_STATUS, 7, rd, ce);

        // Kicks at random intervals never exceeding LOAD.
        lval = 8;
        bus(1, R_LOAD, lval, rd, ce);
        bus(1, R_CTRL, 32'h3, rd, e0);
        while (cyc < e0 + 100) begin
            bus(1, R_KICK, KEY, rd, lk);
            idle($urandom_range(0, 5));
        end
        bus(1, R_KICK, KEY, rd, lk);
        bus(1, R_KICK, 32'h1234, rd, ce);
        bus(0, R_STATUS, 0, rd, ce); check("kick_status", rd, 32'h2);
        bus(0, R_COUNT, 0, rd, ce);  check("badkey_noreload", rd, 32'(lval - (ce - 1 - lk)));
        check("kick_int", int_o, 0);
        bus(1, R_CTRL, 0, rd, ce);
        bus(1, R_STATUS, 7, rd, ce);

        // Valid kick committing on the terminal edge.
        lval = $urandom_range(6, 12);
        bus(1, R_LOAD, lval, rd, ce);
        bus(1, R_CTRL, 32'h3, rd, e0);
        idle(lval - 1);
        bus(1, R_KICK, KEY, rd, ce);
        check("col_commit", ce, e0 + lval + 1);
        bus(0, R_COUNT, 0, rd, ce);  check("col_count", rd, 32'(lval - 1));
        bus(0, R_STATUS, 0, rd, ce); check("col_status", rd, 0);
        bus(1, R_CTRL, 0, rd, ce);

        // Edge values and lock.
        bus(1, R_LOAD, 0, rd, ce);
        bus(0, R_LOAD, 0, rd, ce);   check("load0", rd, 1);
        bus(1, R_CTRL, 32'h9, rd, ce);
        bus(1, R_CTRL, 0, rd, ce);
        bus(0, R_CTRL, 0, rd, ce);   check("lock_ctrl", rd, 32'h9);
        bus(1, R_LOAD, 32'h77, rd, ce);
        bus(0, R_LOAD, 0, rd, ce);   check("lock_load", rd, 1);

        // Reset while the reset request is active.
        rst_i = 1'b1; idle(1); rst_i = 1'b0;
        bus(1, R_LOAD, 3, rd, ce);
        bus(1, R_CTRL, 32'h5, rd, e0);
        lim = cyc + 100;
        while (!rst_req_o && cyc < lim) idle(1);
        check("rr2_rise", cyc, e0 + 7);
        idle(3);
        rst_i = 1'b1;
        idle(1);
        check("rr2_drop", rst_req_o, 0);
        rst_i = 1'b0;
        bus(0, R_CTRL, 0, rd, ce);   check("rr2_ctrl", rd, 0);
        bus(0, R_LOAD, 0, rd, ce);   check("rr2_load", rd, 32'hFFFF_FFFF);
        bus(0, R_STATUS, 0, rd, ce); check("rr2_status", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
